// File: rtl/twiddle_pkg.sv
// rtl/twiddle_pkg.sv - shared types and helpers for the twiddle table writer
// Contents: state_t (writer FSM states), calc_aw (address width from depth),
//           bitreverse (reverse the low 'bits' bits of a word).
package twiddle_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WR        = 2'd1,
    MUL       = 2'd2,
    WAIT_FULL = 2'd3
  } state_t;

  // Address width is clog2(depth), but never less than one bit.
  function automatic int calc_aw(input int depth);
    int n;
    n = $clog2(depth);
    return (n < 1) ? 1 : n;
  endfunction

  // Reverse bits [bits-1:0] of v; bits above that come back as zero.
  function automatic logic [31:0] bitreverse(input logic [31:0] v, input int bits);
    logic [31:0] r;
    logic [31:0] t;
    r = '0;
    t = v;
    for (int k = 0; k < 32; k++) begin
      if (k < bits) begin
        r = {r[30:0], t[0]};
        t = t >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/twiddle_gen_writer_if.sv
// rtl/twiddle_gen_writer_if.sv - table-RAM write bus between writer and RAM
// Signals: write_en/write_addr/write_data (writer -> RAM), full_ram (RAM -> writer).
// Modports: master (writer side), slave (RAM side).
interface twiddle_gen_writer_if #(
  parameter int W  = 32,
  parameter int AW = 3
) ();

  logic          write_en;
  logic [AW-1:0] write_addr;
  logic [W-1:0]  write_data;
  logic          full_ram;

  modport master (
    output write_en,
    output write_addr,
    output write_data,
    input  full_ram
  );

  modport slave (
    input  write_en,
    input  write_addr,
    input  write_data,
    output full_ram
  );

endinterface

// File: rtl/mod_mul_serial.sv
// rtl/mod_mul_serial.sv - bit-serial interleaved modular multiplier (a*b mod q)
// Ports: clk, rst (sync, active-high), start (load operands), a, b, q (W bits,
//        a < q and b < q expected), busy (bits still in flight), valid (one-cycle
//        pulse, result ready), result (W bits, always < q). Latency: W cycles.
module mod_mul_serial #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] q,
  output logic         busy,
  output logic         valid,
  output logic [W-1:0] result
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  m_q;
  logic [W-1:0]  acc_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic          valid_q;

  // One multiplier bit: acc = 2*acc mod m, then add a mod m if the bit is set.
  // Both sums stay below 2m < 2^(W+1), so a W+1 bit intermediate never wraps.
  function automatic logic [W-1:0] step(input logic [W-1:0] acc, input logic [W-1:0] av,
                                        input logic [W-1:0] m, input logic bitv);
    logic [W:0] d;
    d = {acc, 1'b0};
    if (d >= {1'b0, m}) d = d - {1'b0, m};
    if (bitv) begin
      d = d + {1'b0, av};
      if (d >= {1'b0, m}) d = d - {1'b0, m};
    end
    return d[W-1:0];
  endfunction

  // The MSB is consumed on the load edge itself, so W edges cover all W bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (start) begin
        a_q   <= a;
        m_q   <= q;
        b_q   <= b << 1;
        acc_q <= step('0, a, q, b[W-1]);
        cnt_q <= CW'(W - 1);
        if (W == 1) begin
          valid_q <= 1'b1;
        end else begin
          busy_q <= 1'b1;
        end
      end else if (busy_q) begin
        acc_q <= step(acc_q, a_q, m_q, b_q[W-1]);
        b_q   <= b_q << 1;
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy_q  <= 1'b0;
          valid_q <= 1'b1;
        end
      end
    end
  end

  assign busy   = busy_q;
  assign valid  = valid_q;
  assign result = acc_q;

endmodule

// File: rtl/twiddle_gen_writer.sv
// rtl/twiddle_gen_writer.sv - generates omega^i mod q for i = 0..DEPTH-1 and writes the table RAM
// Ports: clk, rst (sync, active-high, shared with the table RAM), start (one-cycle request),
//        omega, q (sampled on accepted start), busy, done (pulse when RAM full),
//        err (pulse on rejected start), ram (master side of the RAM write bus).
// Option: define TWIDDLE_BITREV_EN to write entry i at bit-reversed address (DEPTH power of two).
module twiddle_gen_writer
  import twiddle_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 8,
  parameter int AW    = calc_aw(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [W-1:0]                omega,
  input  logic [W-1:0]                q,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  twiddle_gen_writer_if.master        ram
);

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [W-1:0]  omega_q, omega_d;
  logic [W-1:0]  mod_q, mod_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [W-1:0]  data_q, data_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          mul_start;
  logic          mul_busy;
  logic          mul_valid;
  logic [W-1:0]  mul_result;
  logic          last_entry;

  function automatic logic [AW-1:0] map_addr(input logic [AW-1:0] i);
`ifdef TWIDDLE_BITREV_EN
    logic [31:0] r;
    r = bitreverse(32'(i), $clog2(DEPTH));
    return r[AW-1:0];
`else
    return i;
`endif
  endfunction

  assign last_entry = (idx_q == AW'(DEPTH - 1));

  // The last written word doubles as the multiplicand for the next entry.
  mod_mul_serial #(.W(W)) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (mul_start),
    .a      (data_q),
    .b      (omega_q),
    .q      (mod_q),
    .busy   (mul_busy),
    .valid  (mul_valid),
    .result (mul_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      omega_q <= '0;
      mod_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      omega_q <= omega_d;
      mod_q   <= mod_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // WR is the cycle in which write_en is visible; the write itself is
  // registered on the transition into WR so all outputs come from flops.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    omega_d   = omega_q;
    mod_d     = mod_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    mul_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if ((q >= W'(2)) && (omega < q)) begin
            omega_d = omega;
            mod_d   = q;
            idx_d   = '0;
            we_d    = 1'b1;
            addr_d  = map_addr('0);
            data_d  = W'(1);
            busy_d  = 1'b1;
            state_d = WR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      WR: begin
        if (last_entry) begin
          state_d = WAIT_FULL;
        end else begin
          mul_start = !mul_busy;
          state_d   = MUL;
        end
      end
      MUL: begin
        if (mul_valid) begin
          idx_d   = idx_q + AW'(1);
          we_d    = 1'b1;
          addr_d  = map_addr(idx_q + AW'(1));
          data_d  = mul_result;
          state_d = WR;
        end
      end
      WAIT_FULL: begin
        if (ram.full_ram) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ram.write_en   = we_q;
  assign ram.write_addr = addr_q;
  assign ram.write_data = data_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;

endmodule

// File: tb/tb_twiddle_gen_writer.sv
// tb/tb_twiddle_gen_writer.sv - directed self-checking bench for twiddle_gen_writer
module tb_twiddle_gen_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start8, start1;
  logic [31:0] omega8, q8, omega1, q1;
  logic        busy8, done8, err8;
  logic        busy1, done1, err1;
  logic        full_en8, full_en1;

  twiddle_gen_writer_if #(.W(32), .AW(3)) ram8 ();
  twiddle_gen_writer_if #(.W(32), .AW(1)) ram1 ();

  twiddle_gen_writer #(.W(32), .DEPTH(8)) dut8 (
    .clk (clk), .rst (rst), .start (start8), .omega (omega8), .q (q8),
    .busy (busy8), .done (done8), .err (err8), .ram (ram8)
  );

  twiddle_gen_writer #(.W(32), .DEPTH(1)) dut1 (
    .clk (clk), .rst (rst), .start (start1), .omega (omega1), .q (q1),
    .busy (busy1), .done (done1), .err (err1), .ram (ram1)
  );

  // Table RAM written-flag model, cleared by the shared reset.
  logic [7:0] wr8;
  logic       wr1;
  always @(posedge clk) begin
    if (rst) begin
      wr8 <= '0;
      wr1 <= 1'b0;
    end else begin
      if (ram8.write_en) wr8[ram8.write_addr] <= 1'b1;
      if (ram1.write_en) wr1 <= 1'b1;
    end
  end
  assign ram8.full_ram = (&wr8) & full_en8;
  assign ram1.full_ram = wr1 & full_en1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int wa8[$];
  int wd8[$];
  int wc8[$];
  int dc8[$];
  int n1w = 0;
  always @(negedge clk) begin
    if (ram8.write_en) begin
      wa8.push_back(int'(ram8.write_addr));
      wd8.push_back(int'(ram8.write_data));
      wc8.push_back(cyc);
    end
    if (done8) dc8.push_back(cyc);
    if (ram1.write_en) n1w = n1w + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_wr8(input int n, input int budget);
    int k;
    k = 0;
    while (wa8.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk("wait_writes", 64'(wa8.size() >= n), 1);
  endtask

  task automatic wait_done8(input int n, input int budget);
    int k;
    k = 0;
    while (dc8.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk("wait_done", 64'(dc8.size() >= n), 1);
  endtask

  int exp_data[8] = '{1, 2, 4, 8, 16, 15, 13, 9};
`ifdef TWIDDLE_BITREV_EN
  int exp_addr[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
  int exp_addr[8] = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif

  int base;
  int dbase;

  initial begin
    rst = 1'b1;
    start8 = 1'b0; omega8 = '0; q8 = '0; full_en8 = 1'b0;
    start1 = 1'b0; omega1 = '0; q1 = '0; full_en1 = 1'b0;
    tick();
    tick();
    chk("rst_we", ram8.write_en, 0);
    chk("rst_addr", ram8.write_addr, 0);
    chk("rst_data", ram8.write_data, 0);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_err", err8, 0);
    chk("rst_busy1", busy1, 0);

    // Rejected starts: omega >= q, then q < 2.
    rst = 1'b0;
    base = wa8.size();
    start8 = 1'b1; omega8 = 17; q8 = 17;
    tick();
    start8 = 1'b0;
    chk("err_pulse", err8, 1);
    chk("err_busy", busy8, 0);
    chk("err_we", ram8.write_en, 0);
    tick();
    chk("err_once", err8, 0);
    chk("err_busy2", busy8, 0);
    start8 = 1'b1; omega8 = 0; q8 = 1;
    tick();
    start8 = 1'b0;
    chk("err_q1", err8, 1);
    tick();
    chk("err_nowrite", wa8.size(), base);

    // Main table, q=17, omega=2, with a start re-pulse while busy.
    base = wa8.size();
    start8 = 1'b1; omega8 = 2; q8 = 17;
    tick();
    start8 = 1'b0;
    chk("first_we", ram8.write_en, 1);
    chk("first_addr", ram8.write_addr, exp_addr[0]);
    chk("first_data", ram8.write_data, 1);
    chk("first_busy", busy8, 1);
    tick();
    chk("we_single", ram8.write_en, 0);
    for (int i = 0; i < 4; i++) tick();
    chk("hold_addr", ram8.write_addr, exp_addr[0]);
    chk("hold_data", ram8.write_data, 1);
    start8 = 1'b1; omega8 = 3; q8 = 5;
    tick();
    start8 = 1'b0;
    chk("repulse_err", err8, 0);
    chk("repulse_busy", busy8, 1);
    wait_wr8(base + 8, 400);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("addr%0d", i), wa8[base + i], exp_addr[i]);
      chk($sformatf("data%0d", i), wd8[base + i], exp_data[i]);
      if (i > 0) chk($sformatf("gap%0d", i), wc8[base + i] - wc8[base + i - 1], 33);
    end
    for (int i = 0; i < 5; i++) tick();
    chk("wait_busy", busy8, 1);
    chk("wait_done_low", done8, 0);
    chk("wait_nowrite", wa8.size(), base + 8);
    full_en8 = 1'b1;
    tick();
    chk("done_pulse", done8, 1);
    chk("done_busy", busy8, 0);
    tick();
    chk("done_once", done8, 0);

    // Reset during the third multiply, then an immediate restart.
    base = wa8.size();
    start8 = 1'b1; omega8 = 2; q8 = 17;
    tick();
    start8 = 1'b0;
    wait_wr8(base + 3, 200);
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    chk("mrst_we", ram8.write_en, 0);
    chk("mrst_addr", ram8.write_addr, 0);
    chk("mrst_data", ram8.write_data, 0);
    chk("mrst_busy", busy8, 0);
    chk("mrst_done", done8, 0);
    chk("mrst_err", err8, 0);
    rst = 1'b0;
    base = wa8.size();
    dbase = dc8.size();
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    chk("restart_we", ram8.write_en, 1);
    chk("restart_addr", ram8.write_addr, 0);
    chk("restart_data", ram8.write_data, 1);
    wait_wr8(base + 8, 400);
    chk("restart_last_addr", wa8[base + 7], exp_addr[7]);
    chk("restart_last_data", wd8[base + 7], 9);
    wait_done8(dbase + 1, 20);
    chk("done_after_full", dc8[dbase] - wc8[base + 7], 2);
    tick();
    chk("restart_idle", busy8, 0);

    // DEPTH=1: a single write, then done once full_ram rises.
    start1 = 1'b1; omega1 = 3; q1 = 7;
    tick();
    start1 = 1'b0;
    chk("d1_we", ram1.write_en, 1);
    chk("d1_addr", ram1.write_addr, 0);
    chk("d1_data", ram1.write_data, 1);
    chk("d1_busy", busy1, 1);
    for (int i = 0; i < 40; i++) tick();
    chk("d1_single", n1w, 1);
    chk("d1_wait_done", done1, 0);
    chk("d1_wait_busy", busy1, 1);
    full_en1 = 1'b1;
    tick();
    chk("d1_done", done1, 1);
    chk("d1_idle", busy1, 0);
    tick();
    chk("d1_done_once", done1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
